lsu_ctrl: RTL and testbench

- Parametrised load/store controller for the MEM stage of the 5-stage core. Next generation of the single-request mem_stage counter.
- Adds a DEPTH_P-entry posted store buffer, so stores retire without waiting for dmem.
- Adds misaligned-word detection and a dmem response timeout, both raising a sticky exception.
- Sits between the XM pipeline register and data memory. Loads drain the store buffer first and have no store-to-load forwarding.

---
 rtl/lsu_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller with a posted store buffer.
// Stores retire into a circular buffer and drain to dmem in order; loads wait for the
// buffer to empty, then issue. One dmem transaction is in flight at a time. Misaligned
// word accesses and over-long dmem transactions raise a sticky exception.
module lsu_ctrl #(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 32,
    parameter int unsigned DEPTH_P      = 4,
    parameter int unsigned TIMEOUT_P    = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             op_valid_i,
    input  logic                             op_wen_i,
    input  logic                             op_byte_i,
    input  logic [ADDR_WIDTH_P-1:0]          op_addr_i,
    input  logic [DATA_WIDTH_P-1:0]          op_wdata_i,
    input  logic                             hold_i,
    output logic                             stall_o,
    output logic                             load_done_o,
    output logic [DATA_WIDTH_P-1:0]          load_data_o,
    output logic                             mem_valid_o,
    output logic                             mem_wen_o,
    output logic                             mem_byte_o,
    output logic [ADDR_WIDTH_P-1:0]          mem_addr_o,
    output logic [DATA_WIDTH_P-1:0]          mem_wdata_o,
    input  logic                             mem_yumi_i,
    input  logic                             mem_rvalid_i,
    input  logic [DATA_WIDTH_P-1:0]          mem_rdata_i,
    output logic                             mem_ryumi_o,
    output logic [$clog2(DEPTH_P+1)-1:0]     sb_count_o,
    output logic                             exception_o
);

    localparam int unsigned CntW = $clog2(DEPTH_P + 1);
    localparam int unsigned PtrW = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int unsigned TmoW = (TIMEOUT_P > 0) ? $clog2(TIMEOUT_P + 1) : 1;
    localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_P);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH_P);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH_P-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH_P-1:0] req_wdata_q, req_wdata_d;
    logic                    req_wen_q, req_wen_d;
    logic                    req_byte_q, req_byte_d;

    logic [ADDR_WIDTH_P-1:0] sb_addr_q  [DEPTH_P];
    logic [DATA_WIDTH_P-1:0] sb_wdata_q [DEPTH_P];
    logic [DEPTH_P-1:0]      sb_byte_q;
    logic [PtrW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]         count_q, count_d;
    logic [TmoW-1:0]         tmo_q, tmo_d;
    logic                    exc_q, exc_d;

    logic misaligned, st_op, ld_op, in_flight, sb_full;
    logic ld_rsp, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH_P - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Op decode, handshakes and core-facing outputs
    always_comb begin
        misaligned  = op_valid_i & ~op_byte_i & (op_addr_i[1:0] != 2'b00);
        st_op       = op_valid_i & op_wen_i & ~misaligned;
        ld_op       = op_valid_i & ~op_wen_i & ~misaligned;
        in_flight   = (state_q != StIdle);
        sb_full     = (count_q == CntFull);
        // Store responses are taken at once; load responses wait until the core can commit
        mem_ryumi_o = in_flight & mem_rvalid_i & (req_wen_q | ~hold_i);
        ld_rsp      = mem_ryumi_o & ~req_wen_q;
        pop         = mem_ryumi_o & req_wen_q;
        // Fullness is judged on the registered count, so a same-cycle pop never frees a slot
        push        = st_op & ~sb_full;
        stall_o     = (st_op & sb_full) | (ld_op & ~ld_rsp);
        load_done_o = ld_rsp;
        load_data_o = ld_rsp ? mem_rdata_i : '0;
    end

    // Transaction FSM, request register, buffer pointers, timeout and exception next-state
    always_comb begin
        state_d     = state_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wen_d   = req_wen_q;
        req_byte_d  = req_byte_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != '0) begin
                    state_d     = StReq;
                    req_addr_d  = sb_addr_q[rd_ptr_q];
                    req_wdata_d = sb_wdata_q[rd_ptr_q];
                    req_wen_d   = 1'b1;
                    req_byte_d  = sb_byte_q[rd_ptr_q];
                end else if (ld_op) begin
                    state_d     = StReq;
                    req_addr_d  = op_addr_i;
                    req_wdata_d = '0;
                    req_wen_d   = 1'b0;
                    req_byte_d  = op_byte_i;
                end
            end
            StReq: begin
                if (mem_ryumi_o) begin
                    state_d = StIdle;
                end else if (mem_yumi_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_ryumi_o) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Counts cycles spent in REQ/WAIT, saturating so it cannot wrap
        if (!in_flight || state_d == StIdle) begin
            tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
            tmo_d = tmo_q + TmoW'(1);
        end else begin
            tmo_d = tmo_q;
        end

        exc_d = exc_q | misaligned;
        if ((TIMEOUT_P != 0) && in_flight && (state_d != StIdle) && (tmo_d == TmoMax)) begin
            exc_d = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wen_q   <= 1'b0;
            req_byte_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wen_q   <= req_wen_d;
            req_byte_q  <= req_byte_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            exc_q       <= exc_d;
        end
    end

    // Store buffer storage, written at the tail on push
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH_P; i++) begin
                sb_addr_q[i]  <= '0;
                sb_wdata_q[i] <= '0;
            end
            sb_byte_q <= '0;
        end else if (push) begin
            sb_addr_q[wr_ptr_q]  <= op_addr_i;
            sb_wdata_q[wr_ptr_q] <= op_wdata_i;
            sb_byte_q[wr_ptr_q]  <= op_byte_i;
        end
    end

    assign mem_valid_o = (state_q == StReq);
    assign mem_wen_o   = req_wen_q;
    assign mem_byte_o  = req_byte_q;
    assign mem_addr_o  = req_addr_q;
    assign mem_wdata_o = req_wdata_q;
    assign sb_count_o  = count_q;
    assign exception_o = exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed ops push expected dmem requests and load data,
// a monitor pops and compares whenever the DUT presents a request acceptance or a load.
module tb_lsu_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid_i = 1'b0, op_wen_i = 1'b0, op_byte_i = 1'b0;
    logic [AW-1:0] op_addr_i = '0;
    logic [DW-1:0] op_wdata_i = '0;
    logic          hold_i = 1'b0;
    logic          stall_o, load_done_o;
    logic [DW-1:0] load_data_o;
    logic          mem_valid_o, mem_wen_o, mem_byte_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          mem_yumi_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [DW-1:0] mem_rdata_i = '0;
    logic          mem_ryumi_o;
    logic [2:0]    sb_count_o;
    logic          exception_o;

    lsu_ctrl #(
        .DATA_WIDTH_P (DW),
        .ADDR_WIDTH_P (AW),
        .DEPTH_P      (DEPTH),
        .TIMEOUT_P    (TMO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid_i   (op_valid_i),
        .op_wen_i     (op_wen_i),
        .op_byte_i    (op_byte_i),
        .op_addr_i    (op_addr_i),
        .op_wdata_i   (op_wdata_i),
        .hold_i       (hold_i),
        .stall_o      (stall_o),
        .load_done_o  (load_done_o),
        .load_data_o  (load_data_o),
        .mem_valid_o  (mem_valid_o),
        .mem_wen_o    (mem_wen_o),
        .mem_byte_o   (mem_byte_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_yumi_i   (mem_yumi_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ryumi_o  (mem_ryumi_o),
        .sb_count_o   (sb_count_o),
        .exception_o  (exception_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wen;
        logic          is_byte;
    } req_t;

    req_t          exp_req[$];
    logic [DW-1:0] exp_load[$];
    logic [DW-1:0] mem_model[logic [AW-1:0]];

    int n_chk  = 0;
    int n_pass = 0;

    // dmem model knobs
    int yumi_dly   = 1;
    int rsp_dly    = 1;
    bit never_yumi = 1'b0;
    int dm_phase   = 0;
    int dm_cnt     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string detail);
        n_chk++;
        $display("FAIL %s: %s", name, detail);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0; op_valid_i = 1'b0; op_wen_i = 1'b0; op_byte_i = 1'b0;
        op_addr_i = '0; op_wdata_i = '0; hold_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic issue(input logic wen, input logic is_byte, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, output int stalls);
        @(posedge clk); #1;
        op_valid_i = 1'b1; op_wen_i = wen; op_byte_i = is_byte;
        op_addr_i = addr; op_wdata_i = wdata;
        stalls = 0;
        @(negedge clk);
        while (stall_o && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        if (stall_o) fail("issue_bound", "stall_o actual 1 after 40 cycles, required 0");
    endtask

    task automatic op_idle();
        @(posedge clk); #1;
        op_valid_i = 1'b0;
    endtask

    task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_req.push_back('{addr: a, wdata: d, wen: 1'b1, is_byte: 1'b0});
    endtask

    task automatic push_load(input logic [AW-1:0] a, input logic b, input logic [DW-1:0] d);
        exp_req.push_back('{addr: a, wdata: '0, wen: 1'b0, is_byte: b});
        exp_load.push_back(d);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        @(negedge clk);
        while ((sb_count_o != 0 || mem_valid_o || mem_rvalid_i) && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(name, sb_count_o, 0);
    endtask

    // Simple dmem: accepts yumi_dly cycles after a request appears, answers rsp_dly later
    initial begin : dmem
        logic          s_valid, s_took, s_wen;
        logic [AW-1:0] s_addr, cur_addr;
        logic [DW-1:0] s_wdata;
        cur_addr = '0;
        forever begin
            @(negedge clk);
            s_valid = mem_valid_o;
            s_took  = mem_rvalid_i & mem_ryumi_o;
            s_addr  = mem_addr_o;
            s_wdata = mem_wdata_o;
            s_wen   = mem_wen_o;
            @(posedge clk); #1;
            if (!reset) begin
                dm_phase = 0; mem_yumi_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
            end else begin
                case (dm_phase)
                    0: if (s_valid && !never_yumi) begin
                        if (yumi_dly <= 1) begin
                            mem_yumi_i = 1'b1; dm_phase = 2;
                        end else begin
                            dm_cnt = yumi_dly - 1; dm_phase = 1;
                        end
                    end
                    1: begin
                        dm_cnt--;
                        if (dm_cnt == 0) begin
                            mem_yumi_i = 1'b1; dm_phase = 2;
                        end
                    end
                    2: begin
                        mem_yumi_i = 1'b0;
                        cur_addr = s_addr;
                        if (s_wen) mem_model[s_addr] = s_wdata;
                        if (rsp_dly <= 1) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i = mem_model.exists(cur_addr) ? mem_model[cur_addr] : '0;
                            dm_phase = 4;
                        end else begin
                            dm_cnt = rsp_dly - 1; dm_phase = 3;
                        end
                    end
                    3: begin
                        dm_cnt--;
                        if (dm_cnt == 0) begin
                            mem_rvalid_i = 1'b1;
                            mem_rdata_i = mem_model.exists(cur_addr) ? mem_model[cur_addr] : '0;
                            dm_phase = 4;
                        end
                    end
                    default: if (s_took) begin
                        mem_rvalid_i = 1'b0; mem_rdata_i = '0; dm_phase = 0;
                    end
                endcase
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        req_t          e;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (reset) begin
                if (mem_valid_o && mem_yumi_i) begin
                    if (exp_req.size() == 0) begin
                        fail("req_unexpected", $sformatf("addr 0x%0h accepted, required none",
                                                         mem_addr_o));
                    end else begin
                        e = exp_req.pop_front();
                        chk("req_addr", mem_addr_o, e.addr);
                        chk("req_wen", mem_wen_o, e.wen);
                        chk("req_byte", mem_byte_o, e.is_byte);
                        if (e.wen) chk("req_wdata", mem_wdata_o, e.wdata);
                        else chk("load_after_drain", sb_count_o, 0);
                    end
                end
                if (load_done_o) begin
                    if (exp_load.size() == 0) begin
                        fail("load_unexpected", $sformatf("data 0x%0h, required none",
                                                          load_data_o));
                    end else begin
                        d = exp_load.pop_front();
                        chk("load_data", load_data_o, d);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at 500us, required $finish");
        $fatal(1);
    end

    initial begin : main
        int st;
        bit seen;
        do_reset();

        // Reset state and single store
        @(negedge clk);
        chk("rst_stall", stall_o, 0);
        chk("rst_mem_valid", mem_valid_o, 0);
        chk("rst_load_done", load_done_o, 0);
        chk("rst_sb_count", sb_count_o, 0);
        chk("rst_exception", exception_o, 0);
        chk("rst_ryumi", mem_ryumi_o, 0);
        yumi_dly = 1; rsp_dly = 2;
        push_store(32'h10, 32'hDEADBEEF);
        issue(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, st);
        chk("t1_stall", st, 0);
        chk("t1_cnt0", sb_count_o, 0);
        op_idle();
        @(negedge clk);
        chk("t1_cnt1", sb_count_o, 1);
        wait_drain("t1_cnt_drain");

        // Five back-to-back stores into a four-entry buffer with a slow dmem
        do_reset();
        yumi_dly = 3; rsp_dly = 2;
        for (int i = 0; i < 5; i++) begin
            push_store(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
            issue(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), st);
            chk("t2_stall_cycles", st, (i < 4) ? 0 : 4);
        end
        op_idle();
        wait_drain("t2_drain");
        chk("t2_no_exc", exception_o, 0);

        // Load behind two buffered stores
        do_reset();
        yumi_dly = 1; rsp_dly = 1;
        mem_model[32'h20] = 32'h12345678;
        push_store(32'h200, 32'h11111111);
        issue(1'b1, 1'b0, 32'h200, 32'h11111111, st);
        push_store(32'h204, 32'h22222222);
        issue(1'b1, 1'b0, 32'h204, 32'h22222222, st);
        push_load(32'h20, 1'b0, 32'h12345678);
        issue(1'b0, 1'b0, 32'h20, '0, st);
        chk("t3_stall_cycles", st, 10);
        chk("t3_done", load_done_o, 1);
        chk("t3_data", load_data_o, 32'h12345678);
        op_idle();
        @(negedge clk);
        chk("t3_done_clear", load_done_o, 0);

        // Load response while the core is held
        do_reset();
        mem_model[32'h40] = 32'hCAFEF00D;
        push_load(32'h40, 1'b0, 32'hCAFEF00D);
        @(posedge clk); #1;
        hold_i = 1'b1;
        op_valid_i = 1'b1; op_wen_i = 1'b0; op_byte_i = 1'b0; op_addr_i = 32'h40;
        st = 0;
        @(negedge clk);
        while (!mem_rvalid_i && st < 20) begin
            st++;
            @(negedge clk);
        end
        if (!mem_rvalid_i) fail("t4_rsp_bound", "mem_rvalid_i actual 0, required 1");
        for (int i = 0; i < 3; i++) begin
            chk("t4_ryumi_held", mem_ryumi_o, 0);
            chk("t4_done_held", load_done_o, 0);
            chk("t4_stall_held", stall_o, 1);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        hold_i = 1'b0;
        @(negedge clk);
        chk("t4_ryumi", mem_ryumi_o, 1);
        chk("t4_done", load_done_o, 1);
        chk("t4_stall", stall_o, 0);
        op_idle();

        // Byte load at odd address is legal; word load there is misaligned
        do_reset();
        mem_model[32'h13] = 32'h000000AB;
        push_load(32'h13, 1'b1, 32'h000000AB);
        issue(1'b0, 1'b1, 32'h13, '0, st);
        chk("t5_byte_done", load_done_o, 1);
        op_idle();
        @(negedge clk);
        chk("t5_byte_no_exc", exception_o, 0);
        @(posedge clk); #1;
        op_valid_i = 1'b1; op_wen_i = 1'b0; op_byte_i = 1'b0; op_addr_i = 32'h13;
        @(negedge clk);
        chk("t5_mis_stall", stall_o, 0);
        chk("t5_mis_no_req", mem_valid_o, 0);
        chk("t5_mis_exc_late", exception_o, 0);
        op_idle();
        @(negedge clk);
        chk("t5_mis_exc", exception_o, 1);
        repeat (3) @(negedge clk);
        chk("t5_mis_still_no_req", mem_valid_o, 0);
        chk("t5_exc_sticky", exception_o, 1);

        // Timeout with dmem never accepting, then reset in REQ
        do_reset();
        never_yumi = 1'b1;
        issue(1'b1, 1'b0, 32'h50, 32'h55, st);
        op_idle();
        st = 0;
        seen = 1'b0;
        while (!seen && st < 20) begin
            @(negedge clk);
            seen = mem_valid_o;
            st++;
        end
        if (!seen) fail("t6_req_bound", "mem_valid_o actual 0, required 1");
        chk("t6_exc_c1", exception_o, 0);
        repeat (7) @(negedge clk);
        chk("t6_exc_c8", exception_o, 0);
        @(negedge clk);
        chk("t6_exc_c9", exception_o, 1);
        chk("t6_valid_c9", mem_valid_o, 1);
        chk("t6_cnt", sb_count_o, 1);
        repeat (3) @(negedge clk);
        chk("t6_valid_hold", mem_valid_o, 1);
        chk("t6_addr_hold", mem_addr_o, 32'h50);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_rst_valid", mem_valid_o, 0);
        chk("t6_rst_exc", exception_o, 0);
        chk("t6_rst_cnt", sb_count_o, 0);
        chk("t6_rst_stall", stall_o, 0);
        chk("t6_rst_addr", mem_addr_o, 0);
        chk("t6_rst_wen", mem_wen_o, 0);
        chk("t6_rst_ryumi", mem_ryumi_o, 0);
        chk("t6_rst_ldata", load_data_o, 0);
        never_yumi = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);

        chk("sb_req_queue_empty", exp_req.size(), 0);
        chk("sb_load_queue_empty", exp_load.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
